divisor_restador: RTL

Sequential restoring divider that time-shares a single (N+1)-bit ripple subtractor over N iterations to compute an unsigned quotient and remainder. It is the sequencing controller for the team's `restador` datapath. It loads operands on a start pulse, drives the subtractor once per cycle, and decides per cycle whether to keep or restore the partial remainder. It sits between the operand registers / switch inputs and the result display logic of the lab ALU.

---
 rtl/divisor_pkg.sv | 15 +
 rtl/divisor_restador_restador.sv | 25 ++
 rtl/divisor_restador.sv | 126 ++++++++++++
 3 files changed

// File: rtl/divisor_pkg.sv
// Shared types for the restoring divider: controller states and counter sizing.
package divisor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } estado_t;

  // Iteration counter must hold N-1; never narrower than one bit.
  function automatic int ancho_contador(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/divisor_restador_restador.sv
// Ripple-carry subtractor a - b built as a + ~b + cin; cout=1 means no borrow.
module restador #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] dif,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_etapa
    logic bn;
    assign bn       = ~b[i];
    assign dif[i]   = a[i] ^ bn ^ c[i];
    assign c[i+1]   = (a[i] & bn) | (c[i] & (a[i] ^ bn));
  end

  assign cout = c[N];

endmodule

// File: rtl/divisor_restador.sv
// Sequential restoring divider driving one shared (N+1)-bit restador per cycle.
// Optional macro DIV_CERO_CHECK_EN: a zero divisor skips straight to FIN and flags div_cero.
module divisor_restador
  import divisor_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividendo,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] cociente,
  output logic [N-1:0] residuo,
  output logic         div_cero
);

  localparam int CW = ancho_contador(N);

  estado_t       estado, estado_sig;
  logic [N-1:0]  r;
  logic [N-1:0]  q;
  logic [N-1:0]  d;
  logic [CW-1:0] cnt;

  logic [N:0]    t;
  logic [N:0]    dif;
  logic          cout;
  logic          mantener;
  logic [N-1:0]  r_sig;
  logic [N-1:0]  q_sig;

  // R[N] is provably zero between iterations, so only N bits are stored.
  assign t = {r, q[N-1]};

  restador #(.N(N + 1)) u_restador (
    .a   (t),
    .b   ({1'b0, d}),
    .cin (1'b1),
    .dif (dif),
    .cout(cout)
  );

  // The top difference bit is always zero on a successful subtract.
  assign mantener = cout & ~dif[N];
  assign r_sig    = mantener ? dif[N-1:0] : t[N-1:0];
  assign q_sig    = {q[N-2:0], mantener};

`ifdef DIV_CERO_CHECK_EN
  logic es_cero;
  logic div_cero_q;
  assign es_cero  = (divisor == '0);
  assign div_cero = div_cero_q;
`else
  assign div_cero = 1'b0;
`endif

  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE: begin
        if (start) begin
`ifdef DIV_CERO_CHECK_EN
          estado_sig = es_cero ? FIN : CALC;
`else
          estado_sig = CALC;
`endif
        end
      end
      CALC:    if (cnt == '0) estado_sig = FIN;
      FIN:     estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  assign busy = (estado != IDLE);
  assign done = (estado == FIN);

  // Results are captured on the edge entering FIN so they are valid with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado   <= IDLE;
      r        <= '0;
      q        <= '0;
      d        <= '0;
      cnt      <= '0;
      cociente <= '0;
      residuo  <= '0;
`ifdef DIV_CERO_CHECK_EN
      div_cero_q <= 1'b0;
`endif
    end else begin
      estado <= estado_sig;
      case (estado)
        IDLE: begin
          if (start) begin
            r   <= '0;
            q   <= dividendo;
            d   <= divisor;
            cnt <= CW'(N - 1);
`ifdef DIV_CERO_CHECK_EN
            div_cero_q <= es_cero;
            if (es_cero) begin
              cociente <= '1;
              residuo  <= dividendo;
            end
`endif
          end
        end
        CALC: begin
          r   <= r_sig;
          q   <= q_sig;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            cociente <= q_sig;
            residuo  <= r_sig;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
